// File: rtl/debounce_oneshot.sv
// Push-button debouncer: 2-flop sync, tick-counted acceptance, press/release strobes.
// Optional auto-repeat on long press: define DEBOUNCE_AUTO_REPEAT_EN.
module debounce_oneshot #(
    parameter int STABLE_TICKS = 3,
    parameter int CNT_W        = 8,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    localparam int MAX_A = (STABLE_TICKS > HOLD_TICKS) ? STABLE_TICKS : HOLD_TICKS;
    localparam int MAX_T = (MAX_A > REPEAT_TICKS) ? MAX_A : REPEAT_TICKS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    if (CNT_W < $clog2(MAX_T + 1)) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for tick counts");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             s1;
    logic             s_in;
    logic             acc_press;
    logic             acc_rel;
    logic             rfire;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RELEASED: begin
                if (s_in) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                // A bounce beats a coincident tick
                if (!s_in) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!s_in) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s_in) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign acc_press = (state == WAIT_PRESS) && (state_nxt == PRESSED);
    assign acc_rel   = (state == WAIT_RELEASE) && (state_nxt == RELEASED);

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             rphase;
    logic             rphase_nxt;

    // rphase: first (hold) strobe already given, now in repeat cadence
    always_comb begin
        rcnt_nxt   = rcnt;
        rphase_nxt = rphase;
        rfire      = 1'b0;
        if (state != PRESSED || state_nxt != PRESSED) begin
            rcnt_nxt   = '0;
            rphase_nxt = 1'b0;
        end else if (tick) begin
            if ((!rphase && rcnt == HOLD_LAST) ||
                (rphase && rcnt == REP_LAST)) begin
                rfire      = 1'b1;
                rcnt_nxt   = '0;
                rphase_nxt = 1'b1;
            end else begin
                rcnt_nxt = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else begin
            rcnt   <= rcnt_nxt;
            rphase <= rphase_nxt;
        end
    end
`else
    assign rfire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1          <= 1'b0;
            s_in        <= 1'b0;
            state       <= RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_in;
            s_in        <= s1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= (state_nxt == PRESSED) || (state_nxt == WAIT_RELEASE);
            btn_press   <= acc_press | rfire;
            btn_release <= acc_rel;
        end
    end

endmodule

// File: tb/tb_debounce_oneshot.sv
// Bench for debounce_oneshot: scenario tasks plus a run-length reference model.
// Repeat expectations follow DEBOUNCE_AUTO_REPEAT_EN.
module tb_debounce_oneshot;

    localparam int STABLE = 3;
    localparam int HOLD   = 5;
    localparam int REP    = 2;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit auto_tick = 1'b1;

    debounce_oneshot #(
        .STABLE_TICKS(STABLE),
        .CNT_W(8),
        .HOLD_TICKS(HOLD),
        .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Reference: accepted level m_l; a run starts the first cycle the synced
    // input differs, and acceptance needs STABLE ticks counted after that cycle.
    bit m_s1, m_s, m_l, m_run, m_press, m_rel;
    int m_cnt, m_k;

    always @(posedge clk) begin
        if (!rst) begin
            m_s1 = 0; m_s = 0; m_l = 0; m_run = 0;
            m_cnt = 0; m_k = 0; m_press = 0; m_rel = 0;
        end else begin
            m_press = 0;
            m_rel = 0;
            if (m_s != m_l) begin
                m_k = 0;
                if (!m_run) begin
                    m_run = 1;
                    m_cnt = 0;
                end else if (tick) begin
                    m_cnt++;
                    if (m_cnt == STABLE) begin
                        m_l = ~m_l;
                        m_run = 0;
                        if (m_l) m_press = 1;
                        else m_rel = 1;
                    end
                end
            end else if (m_run) begin
                m_run = 0;
                m_k = 0;
            end else if (m_l && tick) begin
                m_k++;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                if (m_k == HOLD || (m_k > HOLD && (m_k - HOLD) % REP == 0))
                    m_press = 1;
`endif
            end
            m_s = m_s1;
            m_s1 = btn_in;
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_tick) tick = (cyc % 10 == 9);
    endtask

    task automatic test_reset();
        int np = 0;
        rst = 0;
        btn_in = 1;
        for (int i = 0; i < 3; i++) begin
            clk1();
            tests++;
            if ({btn_level, btn_press, btn_release} !== 3'b000) begin
                fails++;
                $display("FAIL reset_hold got=%b%b%b want=000",
                         btn_level, btn_press, btn_release);
            end
        end
        rst = 1;
        for (int i = 0; i < 80; i++) begin
            clk1();
            np += btn_press;
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel}) begin
                fails++;
                $display("FAIL reset_accept cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        tests++;
        if (np !== 1 || btn_level !== 1'b1) begin
            fails++;
            $display("FAIL reset_press_count got=%0d lvl=%b want=1 lvl=1", np, btn_level);
        end
    endtask

    task automatic test_release();
        int np = 0;
        int nr = 0;
        btn_in = 0;
        for (int i = 0; i < 60; i++) begin
            clk1();
            np += btn_press;
            nr += btn_release;
            if (btn_release && btn_level) begin
                fails++;
                $display("FAIL release_level got=1 want=0 on strobe edge");
            end
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel}) begin
                fails++;
                $display("FAIL release_run cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        tests++;
        if (nr !== 1 || np !== 0 || btn_level !== 1'b0) begin
            fails++;
            $display("FAIL release_count got rel=%0d prs=%0d want rel=1 prs=0", nr, np);
        end
    endtask

    task automatic test_bounce();
        int nb = 0;
        int np = 0;
        btn_in = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 0) btn_in = ~btn_in;
            clk1();
            nb += btn_press + btn_release;
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel}) begin
                fails++;
                $display("FAIL bounce_run cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        tests++;
        if (nb !== 0) begin
            fails++;
            $display("FAIL bounce_strobes got=%0d want=0", nb);
        end
        btn_in = 1;
        for (int i = 0; i < 60; i++) begin
            clk1();
            np += btn_press;
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel}) begin
                fails++;
                $display("FAIL bounce_settle cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        tests++;
        if (np !== 1) begin
            fails++;
            $display("FAIL bounce_press_count got=%0d want=1", np);
        end
    endtask

    task automatic test_mid_reset();
        int nr = 0;
        btn_in = 0;
        for (int i = 0; i < 4; i++) clk1();
        rst = 0;
        clk1();
        rst = 1;
        tests++;
        if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset got=%b%b%b want=000",
                     btn_level, btn_press, btn_release);
        end
        for (int i = 0; i < 40; i++) begin
            clk1();
            nr += btn_release + btn_press + btn_level;
        end
        tests++;
        if (nr !== 0) begin
            fails++;
            $display("FAIL mid_reset_after got=%0d want=0 activity", nr);
        end
    endtask

    task automatic test_corner();
        int np = 0;
        auto_tick = 0;
        tick = 0;
        btn_in = 1;
        for (int i = 0; i < 3; i++) clk1();
        tick = 1;
        clk1();
        clk1();
        tick = 0;
        btn_in = 0;
        clk1();
        clk1();
        tick = 1;
        clk1();
        tick = 0;
        tests++;
        if ({btn_level, btn_press, btn_release} !== 3'b000) begin
            fails++;
            $display("FAIL corner_tick_bounce got=%b%b%b want=000",
                     btn_level, btn_press, btn_release);
        end
        for (int i = 0; i < 20; i++) begin
            clk1();
            np += btn_press + btn_level;
        end
        tests++;
        if (np !== 0) begin
            fails++;
            $display("FAIL corner_after got=%0d want=0 activity", np);
        end
        tick = 1;
        btn_in = 1;
        for (int i = 0; i < 12; i++) begin
            clk1();
            np += btn_press;
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel}) begin
                fails++;
                $display("FAIL tick_high cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        btn_in = 0;
        for (int i = 0; i < 12; i++) clk1();
        tick = 0;
        tests++;
        if (btn_level !== 1'b0) begin
            fails++;
            $display("FAIL tick_high_release got=%b want=0", btn_level);
        end
        auto_tick = 1;
    endtask

    task automatic test_auto_repeat();
        int np = 0;
        int nt = 0;
        int guard = 0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        int want = 5;
`else
        int want = 1;
`endif
        btn_in = 1;
        while (!btn_press && guard < 100) begin
            clk1();
            guard++;
        end
        tests++;
        if (!btn_press) begin
            fails++;
            $display("FAIL repeat_accept got=timeout want=press");
        end
        np = btn_press;
        guard = 0;
        while (nt < 12 && guard < 300) begin
            if (tick) nt++;
            clk1();
            guard++;
            np += btn_press;
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel}) begin
                fails++;
                $display("FAIL repeat_run cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        tests++;
        if (np !== want) begin
            fails++;
            $display("FAIL repeat_count got=%0d want=%0d", np, want);
        end
        btn_in = 0;
        for (int i = 0; i < 60; i++) clk1();
    endtask

    task automatic test_random();
        int hold = 0;
        auto_tick = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                btn_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            tick = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) != 0);
            clk1();
            tests++;
            if ({btn_level, btn_press, btn_release} !== {m_l, m_press, m_rel} ||
                (btn_press && btn_release)) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                         btn_level, btn_press, btn_release, m_l, m_press, m_rel);
            end
        end
        rst = 1;
        auto_tick = 1;
    endtask

    initial begin
        rst = 0;
        tick = 0;
        btn_in = 0;
        test_reset();
        test_release();
        test_bounce();
        test_mid_reset();
        test_corner();
        test_auto_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debounce_oneshot.md
Name: debounce_oneshot

Overview:
- Debounces one raw push-button input and produces a clean level plus single-cycle press/release strobes.
- Sits directly downstream of the 10 ms tick generator and uses its one-cycle `tick` pulse as the sample enable.
- Outputs feed the project's counter and display control logic, which must see exactly one `btn_press` strobe per physical press.

Parameters:
- STABLE_TICKS, 3: consecutive ticks the synchronized input must stay at the new level before it is accepted (3 ticks = 30 ms at the 10 ms tick).
- CNT_W, 8: width of the internal tick counter. Must hold max(STABLE_TICKS, HOLD_TICKS, REPEAT_TICKS).
- HOLD_TICKS, 50: auto-repeat only. Ticks held before the first repeat strobe.
- REPEAT_TICKS, 10: auto-repeat only. Ticks between repeat strobes.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clk.
- tick  input  1  one-clk-wide enable pulse from the 10 ms tick generator.
- btn_in  input  1  raw, asynchronous, bouncing button; 1 = pressed.
- btn_level  output  1  debounced level; registered.
- btn_press  output  1  one-clk strobe on an accepted press (and on repeats when enabled).
- btn_release  output  1  one-clk strobe on an accepted release.

Behaviour:
- Synchronizer: two flops, `btn_in` -> s1 -> s_in. 2-clk latency. Both flops reset to 0.
- Reset (rst==0 at a clk edge):
  - state=RELEASED, counter=0.
  - btn_level=0, btn_press=0, btn_release=0.
  - Same result mid-operation; no strobe is emitted because of reset.
- States: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE. Encoding is free.
- RELEASED:
  - s_in==1 -> WAIT_PRESS, counter=0.
  - Otherwise hold.
- WAIT_PRESS:
  - s_in==0 -> RELEASED, counter=0 (bounce).
  - Else, on tick: if counter==STABLE_TICKS-1 -> PRESSED; otherwise counter+1.
  - Without tick: hold.
- PRESSED:
  - s_in==0 -> WAIT_RELEASE, counter=0.
- WAIT_RELEASE:
  - s_in==1 -> PRESSED, counter=0 (bounce).
  - Else, on tick: if counter==STABLE_TICKS-1 -> RELEASED; otherwise counter+1.
- Outputs:
  - btn_level=1 in PRESSED and WAIT_RELEASE; 0 otherwise.
  - btn_press is registered high for exactly the one clk after the WAIT_PRESS->PRESSED edge.
  - btn_release is registered high for exactly the one clk after the WAIT_RELEASE->RELEASED edge.
  - btn_level changes on the same edge that the strobe rises.
- Simultaneous events: bounce (s_in back to the old level) and tick in the same cycle -> the bounce wins, the counter clears, and no acceptance occurs.
- Acceptance timing: needs STABLE_TICKS tick pulses while s_in holds the new level. Total delay after the level settles is between STABLE_TICKS-1 and STABLE_TICKS tick periods, plus 2 sync clks, plus 1 clk.
- Limits:
  - STABLE_TICKS=1 is legal and accepts on the first tick.
  - The counter never wraps; it is cleared on every state change.
  - tick held high continuously is legal and counts one per clk.
- btn_press and btn_release are never high in the same cycle.

Optional Feature:
- Macro: DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - While in PRESSED, a second counter (CNT_W bits) counts ticks.
  - After HOLD_TICKS ticks, btn_press strobes once. Then it strobes every REPEAT_TICKS ticks.
  - The counter clears on leaving PRESSED and on reset.
  - WAIT_RELEASE suspends repeats; returning to PRESSED from a bounce resumes with the counter cleared.
  - Each repeat strobe is 1 clk wide, registered in the clk after the qualifying tick.
- Undefined: no repeat logic is synthesized; btn_press fires only on acceptance.

Test Plan:
- Reset, then bench drives tick every 10 clks:
  - Hold rst=0 for 3 clks with btn_in=1 -> all outputs 0.
  - Release reset with btn_in=1 steady -> btn_level rises after the 3rd tick following sync; btn_press=1 for exactly 1 clk.
- Bounce: btn_in toggles every 4 clks for 60 clks, then settles at 1 -> no strobe during the bounce; exactly one btn_press about 3 ticks after settling.
- Release: from PRESSED, btn_in=0 steady -> btn_release is a 1-clk strobe after 3 ticks; btn_level=0 on the same edge; btn_press stays 0.
- Corner case: btn_in falls so that s_in==0 in the same cycle as a tick while counter==2 in WAIT_PRESS -> state returns to RELEASED and no btn_press.
- Reset mid-operation: rst=0 for 1 clk while in WAIT_RELEASE -> btn_level=0 the next clk, no btn_release strobe, state RELEASED.
- Auto-repeat (DEBOUNCE_AUTO_REPEAT_EN, HOLD_TICKS=5, REPEAT_TICKS=2): hold btn_in=1 for 12 ticks after acceptance -> btn_press strobes at acceptance, then after ticks 5, 7, 9, 11 (5 strobes total).
